// File: rtl/bus_controller3_if.sv
// Bus handshake bundle between the three memory-side requesters and the arbiter.
// master: requester side (drives requests and shared busy); slave: arbiter side.
interface bus_controller3_if;
  logic bus_reqcyc1;
  logic bus_reqcyc2;
  logic bus_reqcyc3;
  logic bus_grant1;
  logic bus_grant2;
  logic bus_grant3;
  logic bus_busy;

  modport master (
    output bus_reqcyc1, bus_reqcyc2, bus_reqcyc3, bus_busy,
    input  bus_grant1, bus_grant2, bus_grant3
  );

  modport slave (
    input  bus_reqcyc1, bus_reqcyc2, bus_reqcyc3, bus_busy,
    output bus_grant1, bus_grant2, bus_grant3
  );
endinterface

// File: rtl/bus_controller3.sv
// Three-requester round-robin bus arbiter (walker=1, load=2, store=3).
// One-hot registered grant held for the owner's transaction, a forced dead
// cycle between owners, and an optional timeout for grants never used.
module bus_controller3 #(
  parameter int GRANT_TIMEOUT = 16,
  parameter int CNT_WIDTH     = 5
) (
  input  logic           clk,
  input  logic           reset,
  bus_controller3_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANTED, GAP} state_t;

  state_t               state_q;
  logic [2:0]           grant_q;
  logic [1:0]           last_q;    // index of last owner, 0..2 (2 = requester 3)
  logic                 seen_q;    // owner has raised bus_busy during this grant
  logic [CNT_WIDTH-1:0] timer_q;
  logic [CNT_WIDTH-1:0] timer_d;

  logic [2:0] req;
  logic [2:0] win_oh;
  logic [1:0] win_idx;
  logic       win_vld;
  logic       own_req;
  logic       timeout_c;
  logic       release_c;

  assign req = {bus.bus_reqcyc3, bus.bus_reqcyc2, bus.bus_reqcyc1};

  assign bus.bus_grant1 = grant_q[0];
  assign bus.bus_grant2 = grant_q[1];
  assign bus.bus_grant3 = grant_q[2];

  // Index visited k-th when searching round-robin after 'last'.
  function automatic logic [1:0] rr_idx(input logic [1:0] last, input int k);
    int s;
    s = int'(last) + 1 + k;
    return 2'(s % 3);
  endfunction

  // Round-robin winner search starting just past the last owner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!win_vld && req[rr_idx(last_q, k)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(last_q, k);
      end
    end
    win_oh = 3'(3'b001 << win_idx);
  end

  // Release conditions evaluated while GRANTED; timer saturates.
  always_comb begin
    timer_d   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    own_req   = |(req & grant_q);
    timeout_c = (GRANT_TIMEOUT != 0) && !seen_q &&
                (timer_q == CNT_WIDTH'(GRANT_TIMEOUT - 1));
    release_c = (seen_q && !bus.bus_busy) ||
                (!seen_q && !own_req && !bus.bus_busy) ||
                timeout_c;
  end

  // Arbiter FSM with registered grants. GAP holds all grants low for one
  // cycle and arbitrates in that same cycle, so the next owner's grant
  // appears two cycles after the release condition with one dead cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd2;
      seen_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          grant_q <= '0;
          if (win_vld && !bus.bus_busy) begin
            state_q <= GRANTED;
            grant_q <= win_oh;
            last_q  <= win_idx;
            seen_q  <= 1'b0;
            timer_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANTED: begin
          seen_q  <= seen_q | bus.bus_busy;
          timer_q <= timer_d;
          if (release_c) begin
            grant_q <= '0;
            state_q <= GAP;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_controller3.sv
// Bench for bus_controller3: table of round-robin vectors plus hand-written
// sequences for long busy, withdrawal, timeout and asynchronous reset.
module tb_bus_controller3;
  logic clk = 1'b0;
  logic reset = 1'b1;

  bus_controller3_if bif();

  bus_controller3 #(.GRANT_TIMEOUT(16), .CNT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] req;
    logic       busy;
    logic [2:0] gnt;
  } vec_t;

  vec_t       tbl[$];
  logic [2:0] exp_q[$];

  function automatic logic [2:0] gnts();
    return {bif.bus_grant3, bif.bus_grant2, bif.bus_grant1};
  endfunction

  task automatic drive(input logic [2:0] req, input logic busy);
    bif.bus_reqcyc1 = req[0];
    bif.bus_reqcyc2 = req[1];
    bif.bus_reqcyc3 = req[2];
    bif.bus_busy    = busy;
  endtask

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: grants got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, queue the expected grants, compare after the edge.
  task automatic cyc(input string nm, input logic [2:0] req, input logic busy,
                     input logic [2:0] exp);
    logic [2:0] e;
    drive(req, busy);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(nm, gnts(), e);
  endtask

  task automatic do_reset(input logic [2:0] req);
    reset = 1'b1;
    drive(req, 1'b0);
    @(posedge clk);
    #1;
    check("reset_a", gnts(), 3'b000);
    @(posedge clk);
    #1;
    check("reset_b", gnts(), 3'b000);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] g;
    logic [2:0] nx;

    // Reset with every requester asking; requester 1 wins first.
    do_reset(3'b111);

    // Round-robin with busy raised one cycle after grant, held three cycles.
    tbl.push_back('{req: 3'b111, busy: 1'b0, gnt: 3'b001});
    for (int o = 0; o < 3; o++) begin
      g  = 3'(3'b001 << o);
      nx = 3'(3'b001 << ((o + 1) % 3));
      tbl.push_back('{req: 3'b111, busy: 1'b0, gnt: g});
      tbl.push_back('{req: 3'b111, busy: 1'b1, gnt: g});
      tbl.push_back('{req: 3'b111, busy: 1'b1, gnt: g});
      tbl.push_back('{req: 3'b111, busy: 1'b1, gnt: g});
      tbl.push_back('{req: 3'b111, busy: 1'b0, gnt: 3'b000});
      tbl.push_back('{req: 3'b111, busy: 1'b0, gnt: nx});
    end
    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("rr%0d", i), tbl[i].req, tbl[i].busy, tbl[i].gnt);

    // Only requester 2, busy held ten cycles; then withdrawal before busy.
    do_reset(3'b010);
    cyc("lb_grant", 3'b010, 1'b0, 3'b010);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("lb_hold%0d", i), 3'b010, 1'b1, 3'b010);
    cyc("lb_drop",    3'b010, 1'b0, 3'b000);
    cyc("lb_regrant", 3'b010, 1'b0, 3'b010);
    cyc("wd_release", 3'b000, 1'b0, 3'b000);

    // Stale busy in IDLE blocks the grant; then timeout of an unused grant.
    do_reset(3'b001);
    cyc("idle_busy", 3'b001, 1'b1, 3'b000);
    cyc("to_grant",  3'b001, 1'b0, 3'b001);
    for (int i = 0; i < 15; i++)
      cyc($sformatf("to_hold%0d", i), 3'b011, 1'b0, 3'b001);
    cyc("to_drop", 3'b011, 1'b0, 3'b000);
    cyc("to_next", 3'b011, 1'b0, 3'b010);

    // Requester 3 withdraws; others rise the same cycle; pointer picks 1.
    do_reset(3'b100);
    cyc("w3_grant",   3'b100, 1'b0, 3'b100);
    cyc("w3_release", 3'b011, 1'b0, 3'b000);
    cyc("w3_next",    3'b011, 1'b0, 3'b001);

    // Reset mid-transaction clears grants at once and restores the pointer.
    cyc("mr_busy", 3'b011, 1'b1, 3'b001);
    #2;
    reset = 1'b1;
    #1;
    check("mr_async", gnts(), 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("mr_after", 3'b011, 1'b0, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
